dpram_reader: RTL and testbench

- Streaming read-side master for the team's dual-port RAM (`dpram`).
- On a START command it walks a contiguous address window in the RAM and drives the RAM read address.
- It absorbs the RAM's one-cycle registered read latency and presents the words as a valid/ready stream with a last-word flag.
- Sits between the RAM read port (RCLK tied to CLK) and any downstream consumer. The RAM's write port stays with the producer.

---
 rtl/dpram_reader.sv | 100 ++++++++++
 tb/tb_dpram_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_reader.sv
// Streaming read master for dpram: walks an address window and
// presents the registered read data as a valid/ready stream.
module dpram_reader #(
  parameter int DATAWL = 8,
  parameter int ADDRWL = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDRWL-1:0] BASE,
  input  logic [ADDRWL-1:0] LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDRWL-1:0] RA,
  input  logic [DATAWL-1:0] RD,
  output logic              OVALID,
  input  logic              OREADY,
  output logic [DATAWL-1:0] ODATA,
  output logic              OLAST
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state, state_nx;

  logic [ADDRWL-1:0] rem;
  logic [1:0]        fv;
  logic [1:0]        fl;
  logic [DATAWL-1:0] qd [4];
  logic [3:0]        ql;
  logic [1:0]        rp;
  logic [1:0]        wp;
  logic [2:0]        cnt;
  logic [2:0]        used;
  logic              push;
  logic              pop;
  logic              issue;
  logic              start_ok;

  assign OVALID   = cnt != 3'd0;
  assign ODATA    = qd[rp];
  assign OLAST    = OVALID & ql[rp];
  assign BUSY     = state != IDLE;
  assign push     = fv[1];
  assign pop      = OVALID & OREADY;
  assign used     = cnt + {2'b0, fv[0]} + {2'b0, fv[1]};
  assign start_ok = (state == IDLE) & START;
  // credit: buffered words plus reads in flight never exceed 4
  assign issue    = (state == READ) & (rem != '0) & (used < 3'd4);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (START) state_nx = READ;
      READ:    if (rem == '0) state_nx = DRAIN;
      DRAIN:   if (pop & OLAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RA   <= '0;
      rem  <= '0;
      fv   <= '0;
      fl   <= '0;
      rp   <= '0;
      wp   <= '0;
      cnt  <= '0;
      ql   <= '0;
      DONE <= 1'b0;
      for (int i = 0; i < 4; i++) qd[i] <= '0;
    end else begin
      DONE <= (state == DRAIN) & pop & OLAST;
      fv   <= {fv[0], start_ok | issue};
      fl   <= {fl[0], start_ok ? (LEN == '0)
                               : (issue & (rem == ADDRWL'(1)))};
      if (start_ok) begin
        RA  <= BASE;
        rem <= LEN;
      end else if (issue) begin
        RA  <= RA + ADDRWL'(1);
        rem <= rem - ADDRWL'(1);
      end
      if (push) begin
        qd[wp] <= RD;
        ql[wp] <= fl[1];
        wp     <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + {2'b0, push} - {2'b0, pop};
    end
  end

endmodule

// File: tb/tb_dpram_reader.sv
// Scoreboard bench for dpram_reader with a behavioural RAM and
// randomized consumer back-pressure.
module tb_dpram_reader;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [AW-1:0] BASE;
  logic [AW-1:0] LEN;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] RA;
  logic [DW-1:0] RD;
  logic          OVALID;
  logic          OREADY;
  logic [DW-1:0] ODATA;
  logic          OLAST;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic [DW-1:0] mem [256];
  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            accepted = 0;
  int            done_cnt = 0;
  int            rmode = 0;
  int            cyc = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic [AW-1:0] cur_base = '0;
  logic [5:0]    pat = 6'b101001;

  dpram_reader #(.DATAWL(DW), .ADDRWL(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .RA(RA), .RD(RD), .OVALID(OVALID),
    .OREADY(OREADY), .ODATA(ODATA), .OLAST(OLAST)
  );

  always #5 CLK = ~CLK;

  // registered-read RAM
  always @(posedge CLK) RD <= mem[RA];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // consumer ready driver
  initial begin
    int step;
    step = 0;
    OREADY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      step++;
      if (rmode == 0)      OREADY = 1'b1;
      else if (rmode == 1) OREADY = pat[step % 6];
      else                 OREADY = 1'($urandom_range(0, 1));
    end
  end

  // monitor
  initial begin
    logic          pst;
    logic [DW-1:0] pd;
    logic          pl;
    logic          plast;
    logic [AW-1:0] off;
    exp_t          e;
    pst = 1'b0;
    pd = '0;
    pl = 1'b0;
    plast = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        pst = 1'b0;
        plast = 1'b0;
      end else begin
        if (pst)
          chk("stall_hold", {OVALID, OLAST, ODATA}, {1'b1, pl, pd});
        if (plast) chk("done_after_last", DONE, 1);
        if (DONE) begin
          done_cnt++;
          chk("busy_at_done", BUSY, 0);
        end
        if (BUSY) begin
          off = RA - cur_base;
          chk("ra_credit", (int'(off) + 1 - accepted) <= 4, 1);
        end
        plast = 1'b0;
        if (OVALID && OREADY) begin
          if (q.size() == 0) begin
            chk("extra_word", 1, 0);
          end else begin
            e = q.pop_front();
            chk("word", {OLAST, ODATA}, {e.l, e.d});
          end
          if (accepted == 0) first_cyc = cyc;
          last_cyc = cyc;
          accepted++;
          plast = OLAST;
        end
        pst = OVALID & ~OREADY;
        pd = ODATA;
        pl = OLAST;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] l,
                     input int mode, input bit lat, input bit inj);
    int d0;
    int n;
    logic [AW-1:0] a;
    @(posedge CLK);
    #1;
    rmode = mode;
    accepted = 0;
    cur_base = b;
    for (int i = 0; i <= int'(l); i++) begin
      a = b + AW'(i);
      q.push_back('{d: mem[a], l: (i == int'(l))});
    end
    d0 = done_cnt;
    BASE = b;
    LEN = l;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    BASE = AW'($urandom);
    LEN = AW'($urandom);
    if (lat) begin
      @(negedge CLK);
      chk("lat_k0", {BUSY, OVALID}, 2'b10);
      @(negedge CLK);
      chk("lat_k1", OVALID, 0);
      @(negedge CLK);
      chk("lat_k2", OVALID, 1);
    end
    if (inj) begin
      repeat (3) @(posedge CLK);
      #1;
      BASE = b + 8'h40;
      LEN = l + 8'd5;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    repeat (4) @(negedge CLK);
    chk("one_done", done_cnt - d0, 1);
    chk("q_empty", q.size(), 0);
    chk("count", accepted, int'(l) + 1);
    chk("idle", BUSY, 0);
    if (mode == 0) chk("gapless", last_cyc - first_cyc, int'(l));
  endtask

  initial begin
    int n;
    int d0;
    RST = 1'b1;
    START = 1'b0;
    BASE = '0;
    LEN = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outs", {BUSY, DONE, RA, OVALID, ODATA, OLAST}, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    mem[3] = 8'h44;
    run(8'h00, 8'd3, 0, 1'b1, 1'b0);
    run(8'h00, 8'd3, 1, 1'b1, 1'b0);
    run(8'h20, 8'd20, 1, 1'b0, 1'b0);

    mem[8'hFE] = 8'hA1;
    mem[8'hFF] = 8'hA2;
    mem[8'h00] = 8'hA3;
    mem[8'h01] = 8'hA4;
    run(8'hFE, 8'd3, 0, 1'b0, 1'b0);
    run(8'h10, 8'hFF, 0, 1'b0, 1'b0);
    run(8'h10, 8'hFF, 2, 1'b0, 1'b0);
    run(8'h00, 8'd0, 0, 1'b1, 1'b0);
    run(8'h30, 8'd15, 0, 1'b0, 1'b1);
    run(8'h50, 8'd12, 2, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++)
      run(AW'($urandom), AW'($urandom_range(0, 40)), 2, 1'b0, 1'b0);

    // abort mid-transfer
    @(posedge CLK);
    #1;
    rmode = 0;
    accepted = 0;
    cur_base = '0;
    for (int i = 0; i < 8; i++)
      q.push_back('{d: mem[i], l: (i == 7)});
    BASE = '0;
    LEN = 8'd7;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    n = 0;
    while (accepted < 2 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("pre_abort_words", accepted >= 2, 1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_outs", {BUSY, DONE, RA, OVALID, ODATA, OLAST}, 0);
    q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("no_done_abort", done_cnt - d0, 0);
    chk("idle_after_abort", {BUSY, OVALID}, 0);
    run(8'h00, 8'd1, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
